// File: rtl/mini_cpu_core_p.sv
// mini_cpu_core_p - parametrised multi-cycle register-machine CPU core.
//
// Fetches 16-bit instructions from an external synchronous ROM and executes
// each one in three cycles (FETCH -> DECODE -> EXEC). It supports ALU ops,
// immediate loads, jumps, conditional branches on a register being zero,
// and HALT. It keeps zero/carry flags and provides a debug register-read port.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   run          issue gate; when low the core waits in FETCH
//   instr_addr   ROM address (always equals pc)
//   instr_rdata  ROM data, valid the cycle after instr_addr
//   dbg_sel      debug register select
//   dbg_data     combinational read of the selected register
//   pc           program counter
//   alu_result   last value written to a register
//   flag_z       zero flag
//   flag_c       carry/borrow flag
//   retire       one-cycle pulse in the EXEC cycle of every instruction
//   illegal      one-cycle pulse in the EXEC cycle of an undefined opcode
//   halted       high once HALT has executed
module mini_cpu_core_p #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int PC_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    output logic [PC_W-1:0]             instr_addr,
    input  logic [15:0]                 instr_rdata,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data,
    output logic [PC_W-1:0]             pc,
    output logic [DATA_W-1:0]           alu_result,
    output logic                        flag_z,
    output logic                        flag_c,
    output logic                        retire,
    output logic                        illegal,
    output logic                        halted
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_ILLO = 4'hB;
    localparam logic [3:0] OP_ILHI = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              z_q, z_d, c_q, c_d;
    logic              retire_q, retire_d;
    logic              illegal_q, illegal_d;
    logic              halted_q, halted_d;

    logic [3:0]        opcode_s;
    logic [RW-1:0]     rd_s, rs_s, rt_s;
    logic [7:0]        imm8_s;
    logic [DATA_W-1:0] op_a_s, op_b_s, rd_val_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic [PC_W-1:0]   pc_inc_s, target_s;
    logic              wr_op_s, carry_s, taken_s, we_s;
    logic [DATA_W-1:0] wdata_s;
    logic              unused_ir_s;

    assign opcode_s    = ir_q[15:12];
    assign rd_s        = ir_q[8 +: RW];
    assign rs_s        = ir_q[4 +: RW];
    assign rt_s        = ir_q[0 +: RW];
    assign imm8_s      = ir_q[7:0];
    // Register index bits above RW are ignored by design.
    assign unused_ir_s = ^ir_q[11:8];
    assign pc_inc_s    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign target_s    = PC_W'(imm8_s);

    // Operand read and ALU evaluation for the instruction held in the IR
    always_comb begin
        op_a_s   = rf_q[rs_s];
        op_b_s   = rf_q[rt_s];
        rd_val_s = rf_q[rd_s];
        // One extra bit captures carry out (ADD) and borrow (SUB).
        sum_s    = {1'b0, op_a_s} + {1'b0, op_b_s};
        diff_s   = {1'b0, op_a_s} - {1'b0, op_b_s};
        wr_op_s  = 1'b0;
        wdata_s  = {DATA_W{1'b0}};
        carry_s  = 1'b0;
        taken_s  = 1'b0;
        case (opcode_s)
            OP_LDI: begin wr_op_s = 1'b1; wdata_s = DATA_W'(imm8_s); end
            OP_ADD: begin wr_op_s = 1'b1; wdata_s = sum_s[DATA_W-1:0]; carry_s = sum_s[DATA_W]; end
            OP_SUB: begin wr_op_s = 1'b1; wdata_s = diff_s[DATA_W-1:0]; carry_s = diff_s[DATA_W]; end
            OP_AND: begin wr_op_s = 1'b1; wdata_s = op_a_s & op_b_s; end
            OP_OR:  begin wr_op_s = 1'b1; wdata_s = op_a_s | op_b_s; end
            OP_XOR: begin wr_op_s = 1'b1; wdata_s = op_a_s ^ op_b_s; end
            OP_MOV: begin wr_op_s = 1'b1; wdata_s = op_a_s; end
            OP_JMP: taken_s = 1'b1;
            OP_BZ:  taken_s = (rd_val_s == {DATA_W{1'b0}});
            OP_BNZ: taken_s = (rd_val_s != {DATA_W{1'b0}});
            default: wr_op_s = 1'b0;
        endcase
    end

    // Sequencer: next state, pc, flags and the retire/illegal/halt pulses
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_d     = alu_q;
        z_d       = z_q;
        c_d       = c_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        halted_d  = halted_q;
        we_s      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Pulses are registered here so they are high during EXEC.
                ir_d      = instr_rdata;
                retire_d  = 1'b1;
                illegal_d = (instr_rdata[15:12] >= OP_ILLO) && (instr_rdata[15:12] <= OP_ILHI);
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (taken_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_inc_s;
                end
                if (wr_op_s) begin
                    we_s  = 1'b1;
                    alu_d = wdata_s;
                    z_d   = (wdata_s == {DATA_W{1'b0}});
                    c_d   = carry_s;
                end else begin
                    we_s  = 1'b0;
                end
                if (opcode_s == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= {PC_W{1'b0}};
            ir_q      <= 16'h0000;
            alu_q     <= {DATA_W{1'b0}};
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_q     <= alu_d;
            z_q       <= z_d;
            c_q       <= c_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    // Register file, written only at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_s) begin
            rf_q[rd_s] <= wdata_s;
        end
    end

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign dbg_data   = rf_q[dbg_sel];
    assign alu_result = alu_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign retire     = retire_q;
    assign illegal    = illegal_q;
    assign halted     = halted_q;
endmodule

// File: tb/tb_mini_cpu_core_p.sv
// Testbench for mini_cpu_core_p: two instances (default parameters and
// DATA_W=16/NUM_REGS=8/PC_W=6), each fed by a synchronous ROM model and
// checked every cycle against an instruction-level reference model.
module tb_mini_cpu_core_p;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst1_n = 1'b0;
    logic run    = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  addr0, pc0;
    logic [15:0] rdata0 = 16'h0000;
    logic [1:0]  sel0 = 2'd0;
    logic [7:0]  dbg0, alu0;
    logic        z0, c0, ret0, ill0, hlt0;

    logic [5:0]  addr1, pc1;
    logic [15:0] rdata1 = 16'h0000;
    logic [2:0]  sel1 = 3'd0;
    logic [15:0] dbg1, alu1;
    logic        z1, c1, ret1, ill1, hlt1;

    logic [15:0] rom0 [16];
    logic [15:0] rom1 [64];

    int n_checks = 0;
    int n_errors = 0;
    int loop_cnt = 0;
    int ill_cnt  = 0;
    int snap;

    mini_cpu_core_p u_dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .instr_addr(addr0), .instr_rdata(rdata0),
        .dbg_sel(sel0), .dbg_data(dbg0), .pc(pc0), .alu_result(alu0), .flag_z(z0),
        .flag_c(c0), .retire(ret0), .illegal(ill0), .halted(hlt0)
    );

    mini_cpu_core_p #(.DATA_W(16), .NUM_REGS(8), .PC_W(6)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .run(run), .instr_addr(addr1), .instr_rdata(rdata1),
        .dbg_sel(sel1), .dbg_data(dbg1), .pc(pc1), .alu_result(alu1), .flag_z(z1),
        .flag_c(c1), .retire(ret1), .illegal(ill1), .halted(hlt1)
    );

    always @(posedge clk) rdata0 <= rom0[addr0];
    always @(posedge clk) rdata1 <= rom1[addr1];

    // ---------------- reference model (architectural state per config) ----
    longint m_rf [2][16];
    longint m_alu [2];
    int     m_pc [2];
    int     m_ph [2];
    bit     m_z [2], m_c [2], m_halt [2];

    function automatic logic [15:0] rom_word(input int k, input int a);
        if (k == 0) return rom0[a];
        else return rom1[a];
    endfunction

    function automatic void m_reset(input int k);
        for (int i = 0; i < 16; i++) m_rf[k][i] = 0;
        m_alu[k] = 0; m_pc[k] = 0; m_ph[k] = 0;
        m_z[k] = 0; m_c[k] = 0; m_halt[k] = 0;
    endfunction

    function automatic void m_exec(input int k, input logic [15:0] w);
        longint mask, a, b, v;
        int nr, pmod, rd, rs, rt, npc, tgt;
        bit wr;
        mask = (longint'(1) << ((k == 0) ? 8 : 16)) - 1;
        nr   = (k == 0) ? 4 : 8;
        pmod = (k == 0) ? 16 : 64;
        rd = int'(w[11:8]) % nr;
        rs = int'(w[7:4]) % nr;
        rt = int'(w[3:0]) % nr;
        a = m_rf[k][rs];
        b = m_rf[k][rt];
        npc = (m_pc[k] + 1) % pmod;
        tgt = int'(w[7:0]) % pmod;
        wr = 1; v = 0;
        case (w[15:12])
            4'h1: begin v = longint'(w[7:0]) & mask; m_c[k] = 0; end
            4'h2: begin v = a + b; m_c[k] = (v > mask); v = v & mask; end
            4'h3: begin m_c[k] = (a < b); v = (a - b) & mask; end
            4'h4: begin v = a & b; m_c[k] = 0; end
            4'h5: begin v = a | b; m_c[k] = 0; end
            4'h6: begin v = a ^ b; m_c[k] = 0; end
            4'h7: begin v = a; m_c[k] = 0; end
            4'h8: begin wr = 0; npc = tgt; end
            4'h9: begin wr = 0; if (m_rf[k][rd] == 0) npc = tgt; end
            4'hA: begin wr = 0; if (m_rf[k][rd] != 0) npc = tgt; end
            4'hF: begin wr = 0; m_halt[k] = 1; end
            default: wr = 0;
        endcase
        if (wr) begin
            m_rf[k][rd] = v;
            m_alu[k] = v;
            m_z[k] = (v == 0);
        end
        m_pc[k] = npc;
    endfunction

    // Three cycles per instruction: issue from fetch when run is high.
    function automatic void m_step(input int k);
        case (m_ph[k])
            0: if (run) m_ph[k] = 1;
            1: m_ph[k] = 2;
            2: begin
                m_exec(k, rom_word(k, m_pc[k]));
                m_ph[k] = m_halt[k] ? 3 : 0;
            end
            default: m_ph[k] = m_ph[k];
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m_reset(0); else m_step(0);
        if (!rst1_n) m_reset(1); else m_step(1);
    end

    // ---------------- checking ----------------
    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void cmp(input int k, input logic [15:0] p, input logic [15:0] ad,
                                input logic [15:0] al, input logic z, input logic c,
                                input logic r, input logic il, input logic h,
                                input logic [15:0] d, input int s);
        logic [15:0] w;
        bit in_exec;
        w = rom_word(k, m_pc[k]);
        in_exec = (m_ph[k] == 2);
        chk($sformatf("c%0d pc", k), p, m_pc[k]);
        chk($sformatf("c%0d instr_addr", k), ad, m_pc[k]);
        chk($sformatf("c%0d alu_result", k), al, m_alu[k]);
        chk($sformatf("c%0d flag_z", k), z, m_z[k]);
        chk($sformatf("c%0d flag_c", k), c, m_c[k]);
        chk($sformatf("c%0d retire", k), r, in_exec);
        chk($sformatf("c%0d illegal", k), il, in_exec && (w[15:12] >= 4'hB) && (w[15:12] <= 4'hE));
        chk($sformatf("c%0d halted", k), h, m_halt[k]);
        chk($sformatf("c%0d dbg_data", k), d, m_rf[k][s]);
    endfunction

    always @(negedge clk) begin
        cmp(0, 16'(pc0), 16'(addr0), 16'(alu0), z0, c0, ret0, ill0, hlt0, 16'(dbg0), int'(sel0));
        cmp(1, 16'(pc1), 16'(addr1), alu1, z1, c1, ret1, ill1, hlt1, dbg1, int'(sel1));
    end

    // Event counters used by the directed tests
    always @(negedge clk) begin
        if (ret0 && pc0 == 4'd2) loop_cnt++;
        if (ill0) ill_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        sel0 = sel0 + 2'd1;
        sel1 = sel1 + 3'd1;
    endtask

    task automatic load0(input int prog);
        for (int i = 0; i < 16; i++) rom0[i] = 16'h0000;
        case (prog)
            0: begin
                rom0[0] = 16'h1105; rom0[1] = 16'h12FE; rom0[2] = 16'h2312;
                rom0[3] = 16'h1007; rom0[4] = 16'h1107; rom0[5] = 16'h3201;
                rom0[6] = 16'h3220; rom0[7] = 16'hF000;
            end
            1: begin
                rom0[0] = 16'h1103; rom0[1] = 16'h1201; rom0[2] = 16'h3112;
                rom0[3] = 16'hA102; rom0[4] = 16'h910F; rom0[15] = 16'hF000;
            end
            default: begin
                rom0[0] = 16'h115A; rom0[1] = 16'hC123; rom0[2] = 16'h1211;
                rom0[3] = 16'hF000;
            end
        endcase
    endtask

    task automatic restart0(input int prog);
        rst_n = 1'b0;
        load0(prog);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom1[i] = 16'h0000;
        rom1[0] = 16'h17FF; rom1[1] = 16'h2677; rom1[2] = 16'h80C5; rom1[5] = 16'hF000;
        load0(0);
        repeat (2) tick();
        chk("reset pc", pc0, 4'h0);
        chk("reset halted", hlt0, 1'b0);
        rst_n = 1'b1;

        // LDI/ADD with carry, then SUB to zero and SUB with borrow
        repeat (9) tick();
        sel0 = 2'd3; #1;
        chk("add r3", dbg0, 8'h03);
        chk("add flag_c", c0, 1'b1);
        chk("add flag_z", z0, 1'b0);
        repeat (9) tick();
        sel0 = 2'd2; #1;
        chk("sub zero r2", dbg0, 8'h00);
        chk("sub zero flag_z", z0, 1'b1);
        chk("sub zero flag_c", c0, 1'b0);
        repeat (3) tick();
        sel0 = 2'd2; #1;
        chk("sub borrow r2", dbg0, 8'hF9);
        chk("sub borrow flag_c", c0, 1'b1);
        repeat (3) tick();
        chk("halt halted", hlt0, 1'b1);
        repeat (3) tick();
        chk("halt pc", pc0, 4'h8);

        // Countdown loop, BZ taken to HALT at the last address
        restart0(1);
        snap = loop_cnt;
        repeat (30) tick();
        sel0 = 2'd1; #1;
        chk("loop r1", dbg0, 8'h00);
        chk("loop body retires", loop_cnt - snap, 3);
        chk("loop halted", hlt0, 1'b1);
        chk("loop pc wrap", pc0, 4'h0);

        // run gating, illegal opcode, run dropped during DECODE
        restart0(2);
        repeat (3) tick();
        run = 1'b0;
        repeat (10) tick();
        sel0 = 2'd1; #1;
        chk("stall pc", pc0, 4'h1);
        chk("stall r1", dbg0, 8'h5A);
        chk("stall retire", ret0, 1'b0);
        run = 1'b1;
        snap = ill_cnt;
        repeat (3) tick();
        sel0 = 2'd2; #1;
        chk("illegal pulses", ill_cnt - snap, 1);
        chk("illegal r2", dbg0, 8'h00);
        chk("illegal alu", alu0, 8'h5A);
        chk("illegal pc", pc0, 4'h2);
        tick();
        run = 1'b0;
        repeat (4) tick();
        sel0 = 2'd2; #1;
        chk("late stop r2", dbg0, 8'h11);
        chk("late stop pc", pc0, 4'h3);
        run = 1'b1;

        // Asynchronous reset in the EXEC cycle of ADD
        restart0(0);
        repeat (8) tick();
        chk("pre-reset retire", ret0, 1'b1);
        rst_n = 1'b0;
        #1;
        sel0 = 2'd1; #1;
        chk("async pc", pc0, 4'h0);
        chk("async alu", alu0, 8'h00);
        chk("async flag_c", c0, 1'b0);
        chk("async retire", ret0, 1'b0);
        chk("async r1", dbg0, 8'h00);
        tick();
        rst_n = 1'b1;
        repeat (9) tick();
        sel0 = 2'd3; #1;
        chk("restart r3", dbg0, 8'h03);

        // Wide configuration
        rst1_n = 1'b1;
        repeat (6) tick();
        sel1 = 3'd6; #1;
        chk("wide r6", dbg1, 16'h01FE);
        chk("wide flag_c", c1, 1'b0);
        repeat (3) tick();
        chk("wide jmp pc", pc1, 6'h05);
        repeat (3) tick();
        chk("wide halted", hlt1, 1'b1);
        chk("wide halt pc", pc1, 6'h06);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
